bms_prot_fsm_nch: RTL and testbench

BMS_PROT_FSM_NCH -- requirements
Module: bms_prot_fsm_nch

---
 rtl/bms_prot_fsm_nch.sv | 200 ++++++++++++++++++++
 tb/tb_bms_prot_fsm_nch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bms_prot_fsm_nch.sv
// Battery-management protection state machine for NCH fault channels.
// Each channel qualifies its raw flag with a debounce/persistence counter
// and a recovery counter. The per-channel warn and fault levels drive a
// four-state supervisor that runs one cycle behind them: NORM, WARN,
// FAULT, SHUTDOWN. Faults are latched until a clear request is accepted.
// SHUTDOWN is left only through reset.
module bms_prot_fsm_nch #(
    parameter int              NCH       = 5,
    parameter int              CW        = 8,
    parameter int              DB        = 5,
    parameter int              PERS      = 20,
    parameter int              RCV       = 4,
    parameter logic [NCH-1:0]  SHDN_MASK = '0,
    parameter logic [NCH-1:0]  CHG_ONLY  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           flt_raw,
    input  logic [NCH-1:0]           flt_msk,
    input  logic                     chg_en,
    input  logic                     clr_req,
    output logic                     clr_ack,
    output logic                     clr_nak,
    output logic [3:0]               state_1hot,
    output logic [NCH-1:0]           warn_vec,
    output logic [NCH-1:0]           fault_vec,
    output logic [$clog2(NCH)-1:0]   first_flt,
    output logic                     first_vld,
    output logic [7:0]               flt_cnt
);

    localparam int IW = $clog2(NCH);

    localparam logic [CW-1:0] DB_C   = CW'(DB);
    localparam logic [CW-1:0] PERS_C = CW'(PERS);
    localparam logic [CW-1:0] RCV_C  = CW'(RCV);

    typedef enum logic [3:0] {
        NORM  = 4'b0001,
        WARN  = 4'b0010,
        FAULT = 4'b0100,
        SHDN  = 4'b1000
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [NCH-1:0] active;
    logic [CW-1:0]  act_cnt [NCH];
    logic [CW-1:0]  rcv_cnt [NCH];
    logic [CW-1:0]  act_run [NCH];
    logic [CW-1:0]  act_nxt [NCH];
    logic [CW-1:0]  rcv_nxt [NCH];
    logic [NCH-1:0] warn_nxt;
    logic [NCH-1:0] fault_nxt;
    logic [NCH-1:0] new_flt;
    logic           clr_accept;
    logic [IW-1:0]  first_idx;
    logic           flt_inc;

    assign state_1hot = state;

    // Channel qualification, persistence/recovery counting and clear arbitration.
    // act_run is the counter update ignoring any clear. New faults are taken
    // from act_run so that a fault appearing on this edge can veto the clear
    // without forming a combinational loop through the clear itself.
    always_comb begin
        active     = flt_raw & flt_msk & (~CHG_ONLY | {NCH{chg_en}});
        new_flt    = '0;
        warn_nxt   = '0;
        fault_nxt  = '0;
        for (int i = 0; i < NCH; i++) begin
            act_run[i] = act_cnt[i];
            rcv_nxt[i] = rcv_cnt[i];
            if (active[i]) begin
                rcv_nxt[i] = '0;
                if (act_cnt[i] < PERS_C) begin
                    act_run[i] = act_cnt[i] + 1'b1;
                end
            end else if (rcv_cnt[i] >= RCV_C - 1'b1) begin
                // Inactive long enough: the channel has recovered.
                act_run[i] = '0;
                rcv_nxt[i] = '0;
            end else begin
                // Short dropout: hold persistence, count recovery time.
                rcv_nxt[i] = rcv_cnt[i] + 1'b1;
            end
            new_flt[i] = (act_run[i] == PERS_C) && !fault_vec[i];
        end

        clr_accept = clr_req && (state == FAULT)
                     && ((fault_vec & warn_vec) == '0)
                     && (new_flt == '0);

        for (int i = 0; i < NCH; i++) begin
            act_nxt[i] = act_run[i];
            if (clr_accept && fault_vec[i]) begin
                act_nxt[i] = '0;
                rcv_nxt[i] = '0;
            end
            warn_nxt[i]  = (act_nxt[i] >= DB_C);
            fault_nxt[i] = (fault_vec[i] && !clr_accept) || new_flt[i];
        end
    end

    // Lowest-index channel among the faults that latch on this edge.
    always_comb begin
        first_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (new_flt[i]) begin
                first_idx = IW'(i);
            end
        end
    end

    // Supervisor next state from the registered warn/fault levels, highest priority first.
    always_comb begin
        state_nxt = state;
        if ((state == SHDN) || ((warn_vec & SHDN_MASK) != '0)) begin
            state_nxt = SHDN;
        end else if (fault_vec != '0) begin
            state_nxt = FAULT;
        end else if (warn_vec != '0) begin
            state_nxt = WARN;
        end else begin
            state_nxt = NORM;
        end
        flt_inc = (state_nxt == FAULT) && (state != FAULT);
    end

    // Supervisor state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORM;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-channel persistence and recovery counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                act_cnt[i] <= '0;
                rcv_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                act_cnt[i] <= act_nxt[i];
                rcv_cnt[i] <= rcv_nxt[i];
            end
        end
    end

    // Per-channel warn level and latched fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_vec  <= '0;
            fault_vec <= '0;
        end else begin
            warn_vec  <= warn_nxt;
            fault_vec <= fault_nxt;
        end
    end

    // First-fault capture, held until an accepted clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_flt <= '0;
            first_vld <= 1'b0;
        end else if (clr_accept) begin
            first_flt <= '0;
            first_vld <= 1'b0;
        end else if (!first_vld && (new_flt != '0)) begin
            first_flt <= first_idx;
            first_vld <= 1'b1;
        end
    end

    // Saturating count of entries into FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt <= 8'd0;
        end else if (flt_inc && (flt_cnt != 8'hFF)) begin
            flt_cnt <= flt_cnt + 8'd1;
        end
    end

    // Clear handshake: exactly one of ack/nak pulses the cycle after a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ack <= 1'b0;
            clr_nak <= 1'b0;
        end else begin
            clr_ack <= clr_req && clr_accept;
            clr_nak <= clr_req && !clr_accept;
        end
    end

endmodule

// File: tb/tb_bms_prot_fsm_nch.sv
// Directed bench for bms_prot_fsm_nch with NCH=5, DB=5, PERS=20, RCV=4,
// channel 2 as shutdown channel and channel 3 as charge-only channel.
module tb_bms_prot_fsm_nch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] flt_raw;
    logic [4:0] flt_msk;
    logic       chg_en;
    logic       clr_req;
    logic       clr_ack;
    logic       clr_nak;
    logic [3:0] state_1hot;
    logic [4:0] warn_vec;
    logic [4:0] fault_vec;
    logic [2:0] first_flt;
    logic       first_vld;
    logic [7:0] flt_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] raw;
        logic       clr;
        logic [3:0] st;
        logic [4:0] warn;
        logic       ack;
        logic       nak;
    } vec_t;

    vec_t vq[$];

    bms_prot_fsm_nch #(
        .NCH(5), .CW(8), .DB(5), .PERS(20), .RCV(4),
        .SHDN_MASK(5'b00100), .CHG_ONLY(5'b01000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flt_raw(flt_raw), .flt_msk(flt_msk),
        .chg_en(chg_en), .clr_req(clr_req), .clr_ack(clr_ack), .clr_nak(clr_nak),
        .state_1hot(state_1hot), .warn_vec(warn_vec), .fault_vec(fault_vec),
        .first_flt(first_flt), .first_vld(first_vld), .flt_cnt(flt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot", 32'($onehot(state_1hot)), 32'd1);
        chk("ack_nak_excl", 32'(clr_ack & clr_nak), 32'd0);
    endtask

    task automatic add(input logic [4:0] raw, input logic clr, input logic [3:0] st,
                       input logic [4:0] warn, input logic ack, input logic nak);
        vec_t v;
        v.raw = raw; v.clr = clr; v.st = st; v.warn = warn; v.ack = ack; v.nak = nak;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        flt_raw = '0; clr_req = 1'b0; chg_en = 1'b0; flt_msk = 5'h1f;
        rst_n = 1'b0;
        #2;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        flt_raw = '0; flt_msk = 5'h1f; chg_en = 1'b0; clr_req = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state_1hot), 32'h1);
        chk("rst_warn",  32'(warn_vec),   32'h0);
        chk("rst_fault", 32'(fault_vec),  32'h0);
        chk("rst_first", 32'({first_vld, first_flt}), 32'h0);
        chk("rst_cnt",   32'(flt_cnt),    32'h0);
        chk("rst_hs",    32'({clr_ack, clr_nak}), 32'h0);
        rst_n = 1'b1;

        // Short activity, warn rise and recovery on ch1.
        repeat (4) add(5'b00010, 0, 4'b0001, 5'b00000, 0, 0);
        repeat (4) add(5'b00000, 0, 4'b0001, 5'b00000, 0, 0);
        repeat (4) add(5'b00010, 0, 4'b0001, 5'b00000, 0, 0);
        add(5'b00010, 0, 4'b0001, 5'b00010, 0, 0);
        repeat (2) add(5'b00010, 0, 4'b0010, 5'b00010, 0, 0);
        repeat (3) add(5'b00000, 0, 4'b0010, 5'b00010, 0, 0);
        add(5'b00000, 0, 4'b0010, 5'b00000, 0, 0);
        add(5'b00000, 0, 4'b0001, 5'b00000, 0, 0);
        // Clear request outside FAULT is refused.
        add(5'b00000, 1, 4'b0001, 5'b00000, 0, 1);
        add(5'b00000, 0, 4'b0001, 5'b00000, 0, 0);
        // Dropout shorter than RCV keeps the persistence count.
        repeat (3) add(5'b00010, 0, 4'b0001, 5'b00000, 0, 0);
        repeat (2) add(5'b00000, 0, 4'b0001, 5'b00000, 0, 0);
        add(5'b00010, 0, 4'b0001, 5'b00000, 0, 0);
        add(5'b00010, 0, 4'b0001, 5'b00010, 0, 0);
        repeat (3) add(5'b00000, 0, 4'b0010, 5'b00010, 0, 0);
        add(5'b00000, 0, 4'b0010, 5'b00000, 0, 0);
        add(5'b00000, 0, 4'b0001, 5'b00000, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            flt_raw = vq[i].raw;
            clr_req = vq[i].clr;
            tick();
            chk($sformatf("t%0d_state", i), 32'(state_1hot), 32'(vq[i].st));
            chk($sformatf("t%0d_warn", i),  32'(warn_vec),   32'(vq[i].warn));
            chk($sformatf("t%0d_ack", i),   32'(clr_ack),    32'(vq[i].ack));
            chk($sformatf("t%0d_nak", i),   32'(clr_nak),    32'(vq[i].nak));
        end
        clr_req = 1'b0;

        // Ch4 persistence to fault, refused then accepted clear.
        do_reset();
        flt_raw = 5'b10000;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 4)  chk("b_warn_pre", 32'(warn_vec), 32'h00);
            if (k == 5)  chk("b_warn",     32'(warn_vec), 32'h10);
            if (k == 19) chk("b_fault_pre", 32'(fault_vec), 32'h00);
        end
        chk("b_fault", 32'(fault_vec), 32'h10);
        chk("b_first", 32'(first_flt), 32'd4);
        chk("b_fvld",  32'(first_vld), 32'd1);
        chk("b_state_warn", 32'(state_1hot), 32'h2);
        tick();
        chk("b_state_fault", 32'(state_1hot), 32'h4);
        chk("b_cnt", 32'(flt_cnt), 32'd1);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("b_nak", 32'({clr_ack, clr_nak}), 32'h1);
        chk("b_fault_kept", 32'(fault_vec), 32'h10);
        flt_raw = '0;
        repeat (4) tick();
        chk("b_warn_clr", 32'(warn_vec), 32'h00);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("b_ack", 32'({clr_ack, clr_nak}), 32'h2);
        chk("b_fault_clr", 32'(fault_vec), 32'h00);
        chk("b_fvld_clr", 32'(first_vld), 32'd0);
        chk("b_state_hold", 32'(state_1hot), 32'h4);
        tick();
        chk("b_state_norm", 32'(state_1hot), 32'h1);
        chk("b_cnt_hold", 32'(flt_cnt), 32'd1);

        // Shutdown channel escalates at warn level; only reset leaves SHUTDOWN.
        do_reset();
        flt_raw = 5'b00100;
        repeat (5) tick();
        chk("c_warn", 32'(warn_vec), 32'h04);
        chk("c_state_pre", 32'(state_1hot), 32'h1);
        flt_raw = '0;
        tick();
        chk("c_state_shdn", 32'(state_1hot), 32'h8);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("c_nak", 32'({clr_ack, clr_nak}), 32'h1);
        chk("c_state_stay", 32'(state_1hot), 32'h8);
        repeat (6) tick();
        chk("c_warn_clr", 32'(warn_vec), 32'h00);
        chk("c_state_sticky", 32'(state_1hot), 32'h8);
        rst_n = 1'b0;
        #2;
        chk("c_async_rst", 32'(state_1hot), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("c_state_after", 32'(state_1hot), 32'h1);

        // Charge-only channel is ignored while not charging.
        do_reset();
        flt_raw = 5'b01000;
        repeat (30) tick();
        chk("d_nowarn", 32'(warn_vec), 32'h00);
        chk("d_state", 32'(state_1hot), 32'h1);
        chg_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 4)  chk("d_warn_pre", 32'(warn_vec), 32'h00);
            if (k == 5)  chk("d_warn",     32'(warn_vec), 32'h08);
            if (k == 19) chk("d_fault_pre", 32'(fault_vec), 32'h00);
            if (k == 20) chk("d_fault",    32'(fault_vec), 32'h08);
        end
        chg_en = 1'b0;

        // Simultaneous faults and a clear colliding with a new fault.
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            flt_raw = {(k >= 6), 2'b00, ((k <= 20) ? 2'b11 : 2'b00)};
            clr_req = (k == 25);
            tick();
            if (k == 20) begin
                chk("e_fault2", 32'(fault_vec), 32'h03);
                chk("e_first", 32'(first_flt), 32'd0);
                chk("e_fvld", 32'(first_vld), 32'd1);
            end
            if (k == 24) chk("e_state", 32'(state_1hot), 32'h4);
        end
        clr_req = 1'b0;
        chk("e_nak", 32'({clr_ack, clr_nak}), 32'h1);
        chk("e_fault3", 32'(fault_vec), 32'h13);
        chk("e_first_hold", 32'(first_flt), 32'd0);

        // Saturation of the FAULT entry counter.
        do_reset();
        for (int it = 0; it < 256; it++) begin
            flt_raw = 5'b00001;
            repeat (20) tick();
            flt_raw = '0;
            repeat (4) tick();
            clr_req = 1'b1; tick(); clr_req = 1'b0;
            chk($sformatf("f%0d_ack", it), 32'(clr_ack), 32'd1);
            tick();
            if (it == 0)   chk("f_cnt1", 32'(flt_cnt), 32'd1);
            if (it == 253) chk("f_cnt254", 32'(flt_cnt), 32'd254);
            if (it == 254) chk("f_cnt255", 32'(flt_cnt), 32'd255);
            if (it == 255) chk("f_cnt_sat", 32'(flt_cnt), 32'd255);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
